// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder
// Brief    : Dual-port (instruction fetch + data) memory responder serving
//            both ports from one unified 32-bit word array, with a fixed
//            per-port response latency and a single-cycle response pulse.
//            Optional random stall injection is enabled by defining
//            MEM_RESPONDER_STALL_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mem_responder #(
  parameter int ADDR_WIDTH   = 10,
  parameter int IMEM_LATENCY = 1,
  parameter int DMEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,             // asynchronous, active-low
  // instruction fetch port
  input  logic [31:0] pc,
  input  logic        imem_read,
  output logic [31:0] instr,
  output logic        imem_resp,
  // data port
  input  logic [31:0] mem_address,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [3:0]  mem_byte_enable,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_resp
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = 16;             // latency counter width

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Unified word array; contents survive reset.
  logic [31:0] mem_q [DEPTH];

  // Extra latency added to an access on its acceptance edge.
  logic [1:0] w_stall;

`ifdef MEM_RESPONDER_STALL_EN
  logic [7:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR x^8+x^6+x^5+x^4+1, stepped every cycle.
  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  // LFSR state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr_q <= 8'hA5;
    else      lfsr_q <= lfsr_d;
  end

  assign w_stall = lfsr_q[1:0];
`else
  assign w_stall = 2'd0;
`endif

  logic [CW-1:0] w_imem_load, w_dmem_load;
  assign w_imem_load = CW'(IMEM_LATENCY - 1) + CW'(w_stall);
  assign w_dmem_load = CW'(DMEM_LATENCY - 1) + CW'(w_stall);

  // --------------------------------------------------------------------------
  // Instruction port
  // --------------------------------------------------------------------------
  state_t                  imem_state_q, imem_state_d;
  logic [CW-1:0]           imem_cnt_q,   imem_cnt_d;
  logic [ADDR_WIDTH-1:0]   imem_addr_q,  imem_addr_d;
  logic [31:0]             instr_q,      instr_d;
  logic                    w_imem_fire;

  // Instruction FSM next state; the array read happens on the edge entering RESP.
  always_comb begin
    imem_state_d = imem_state_q;
    imem_cnt_d   = imem_cnt_q;
    imem_addr_d  = imem_addr_q;
    unique case (imem_state_q)
      S_IDLE: begin
        if (imem_read) begin
          imem_addr_d  = pc[ADDR_WIDTH+1:2];
          imem_cnt_d   = w_imem_load;
          imem_state_d = (w_imem_load == '0) ? S_RESP : S_BUSY;
        end
      end
      S_BUSY: begin
        imem_cnt_d = imem_cnt_q - CW'(1);
        if (imem_cnt_q == CW'(1)) imem_state_d = S_RESP;
      end
      S_RESP:  imem_state_d = S_IDLE;
      default: imem_state_d = S_IDLE;
    endcase
    // _d address equals the live pc when accepting straight into RESP.
    w_imem_fire = (imem_state_d == S_RESP) && (imem_state_q != S_RESP);
    instr_d     = w_imem_fire ? mem_q[imem_addr_d] : instr_q;
  end

  // Instruction port registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      imem_state_q <= S_IDLE;
      imem_cnt_q   <= '0;
      imem_addr_q  <= '0;
      instr_q      <= 32'h0;
    end else begin
      imem_state_q <= imem_state_d;
      imem_cnt_q   <= imem_cnt_d;
      imem_addr_q  <= imem_addr_d;
      instr_q      <= instr_d;
    end
  end

  // --------------------------------------------------------------------------
  // Data port
  // --------------------------------------------------------------------------
  state_t                  dmem_state_q, dmem_state_d;
  logic [CW-1:0]           dmem_cnt_q,   dmem_cnt_d;
  logic [ADDR_WIDTH-1:0]   dmem_addr_q,  dmem_addr_d;
  logic [31:0]             dmem_wdata_q, dmem_wdata_d;
  logic [3:0]              dmem_be_q,    dmem_be_d;
  logic                    dmem_we_q,    dmem_we_d;
  logic [31:0]             mem_rdata_q,  mem_rdata_d;
  logic                    w_dmem_fire;
  logic [31:0]             w_wr_word;

  // Data FSM next state; read data or write commit on the edge entering RESP.
  always_comb begin
    dmem_state_d = dmem_state_q;
    dmem_cnt_d   = dmem_cnt_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    dmem_be_d    = dmem_be_q;
    dmem_we_d    = dmem_we_q;
    unique case (dmem_state_q)
      S_IDLE: begin
        if (mem_read || mem_write) begin
          dmem_addr_d  = mem_address[ADDR_WIDTH+1:2];
          dmem_wdata_d = mem_wdata;
          dmem_be_d    = mem_byte_enable;
          dmem_we_d    = mem_write;      // read+write together is a write
          dmem_cnt_d   = w_dmem_load;
          dmem_state_d = (w_dmem_load == '0) ? S_RESP : S_BUSY;
        end
      end
      S_BUSY: begin
        dmem_cnt_d = dmem_cnt_q - CW'(1);
        if (dmem_cnt_q == CW'(1)) dmem_state_d = S_RESP;
      end
      S_RESP:  dmem_state_d = S_IDLE;
      default: dmem_state_d = S_IDLE;
    endcase
    w_dmem_fire = (dmem_state_d == S_RESP) && (dmem_state_q != S_RESP);
    mem_rdata_d = (w_dmem_fire && !dmem_we_d) ? mem_q[dmem_addr_d] : mem_rdata_q;
    // Merge enabled bytes of the write data over the current word.
    w_wr_word = mem_q[dmem_addr_d];
    for (int b = 0; b < 4; b++) begin
      if (dmem_be_d[b]) w_wr_word[8*b +: 8] = dmem_wdata_d[8*b +: 8];
    end
  end

  // Data port registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dmem_state_q <= S_IDLE;
      dmem_cnt_q   <= '0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= 32'h0;
      dmem_be_q    <= 4'h0;
      dmem_we_q    <= 1'b0;
      mem_rdata_q  <= 32'h0;
    end else begin
      dmem_state_q <= dmem_state_d;
      dmem_cnt_q   <= dmem_cnt_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      dmem_be_q    <= dmem_be_d;
      dmem_we_q    <= dmem_we_d;
      mem_rdata_q  <= mem_rdata_d;
    end
  end

  // Array write; suppressed while reset is asserted so pending writes drop.
  always_ff @(posedge clk) begin
    if (rst && w_dmem_fire && dmem_we_d) begin
      mem_q[dmem_addr_d] <= w_wr_word;
    end
  end

  assign instr     = instr_q;
  assign imem_resp = (imem_state_q == S_RESP);
  assign mem_rdata = mem_rdata_q;
  assign mem_resp  = (dmem_state_q == S_RESP);

  // Address bits outside the word index are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{pc[31:ADDR_WIDTH+2], pc[1:0],
                              mem_address[31:ADDR_WIDTH+2], mem_address[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_responder
// Brief    : Self-checking bench for mem_responder (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        imem_read;
  logic [31:0] instr;
  logic        imem_resp;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_resp;

  int tests  = 0;
  int failed = 0;

  mem_responder #(.ADDR_WIDTH(10), .IMEM_LATENCY(1), .DMEM_LATENCY(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .pc              (pc),
    .imem_read       (imem_read),
    .instr           (instr),
    .imem_resp       (imem_resp),
    .mem_address     (mem_address),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;   // mem_rdata expected during the response
  } vec_t;

  vec_t vecs [15];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One data access; returns read data and the edge count to the response.
  task automatic dmem_op(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] be,
                         output logic [31:0] rdata, output int lat);
    mem_address     = a;
    mem_wdata       = wd;
    mem_byte_enable = be;
    mem_read        = rd;
    mem_write       = wr;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!mem_resp && lat < 20);
    rdata     = mem_rdata;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    tick();
    check("dmem_pulse_single", {31'b0, mem_resp}, 32'h0);
  endtask

  task automatic imem_op(input logic [31:0] a, output logic [31:0] data, output int lat);
    pc        = a;
    imem_read = 1'b1;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!imem_resp && lat < 20);
    data      = instr;
    imem_read = 1'b0;
    tick();
    check("imem_pulse_single", {31'b0, imem_resp}, 32'h0);
  endtask

  initial begin
    logic [31:0] rdata;
    int          lat;
    int          pulses;

    vecs[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000};
    vecs[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b0, 1'b1, 32'h0000_0010, 32'h0000_AB00, 4'h2, 32'hDEAD_BEEF};
    vecs[3]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_ABEF};
    vecs[4]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'h0, 32'hDEAD_ABEF};
    vecs[5]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_ABEF};
    vecs[6]  = '{1'b0, 1'b1, 32'h0000_1012, 32'hCAFE_F00D, 4'hF, 32'hDEAD_ABEF};
    vecs[7]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hCAFE_F00D};
    vecs[8]  = '{1'b0, 1'b1, 32'h0000_0013, 32'h55AA_55AA, 4'h9, 32'hCAFE_F00D};
    vecs[9]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'h55FE_F0AA};
    vecs[10] = '{1'b0, 1'b1, 32'h0000_0020, 32'h1111_2222, 4'hF, 32'h55FE_F0AA};
    vecs[11] = '{1'b0, 1'b1, 32'h0000_0030, 32'h0BAD_F00D, 4'hF, 32'h55FE_F0AA};
    vecs[12] = '{1'b1, 1'b0, 32'h0000_0030, 32'h0,         4'h0, 32'h0BAD_F00D};
    vecs[13] = '{1'b1, 1'b1, 32'h0000_0040, 32'h7777_8888, 4'hF, 32'h0BAD_F00D};
    vecs[14] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,         4'h0, 32'h7777_8888};

    rst = 1'b0;
    pc = 32'h0; imem_read = 1'b0;
    mem_address = 32'h0; mem_read = 1'b0; mem_write = 1'b0;
    mem_byte_enable = 4'h0; mem_wdata = 32'h0;
    tick();
    tick();
    check("reset_imem_resp", {31'b0, imem_resp}, 32'h0);
    check("reset_mem_resp",  {31'b0, mem_resp},  32'h0);
    check("reset_instr",     instr,     32'h0);
    check("reset_mem_rdata", mem_rdata, 32'h0);
    rst = 1'b1;
    tick();

    // Table-driven data port accesses.
    for (int i = 0; i < 15; i++) begin
      dmem_op(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be, rdata, lat);
      check($sformatf("vec%0d_latency", i), lat, 32'd2);
      check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
    end

    // Instruction read sees data written through the data port.
    imem_op(32'h0000_0040, rdata, lat);
    check("imem_latency", lat, 32'd1);
    check("imem_data_0x40", rdata, 32'h7777_8888);

    // Same-edge conflict: dmem write and imem read of 0x20 both enter RESP together.
    mem_address = 32'h20; mem_wdata = 32'h1234_5678; mem_byte_enable = 4'hF;
    mem_write = 1'b1; pc = 32'h20;
    tick();
    check("conflict_no_early_resp", {31'b0, mem_resp}, 32'h0);
    imem_read = 1'b1;
    tick();
    check("conflict_mem_resp",  {31'b0, mem_resp},  32'h1);
    check("conflict_imem_resp", {31'b0, imem_resp}, 32'h1);
    check("conflict_old_instr", instr, 32'h1111_2222);
    mem_write = 1'b0; imem_read = 1'b0;
    tick();
    imem_op(32'h0000_0020, rdata, lat);
    check("conflict_new_instr", rdata, 32'h1234_5678);

    // Reset while a write to 0x30 is in BUSY.
    mem_address = 32'h30; mem_wdata = 32'hFFFF_FFFF; mem_byte_enable = 4'hF;
    mem_write = 1'b1;
    tick();                       // accepted, now BUSY
    rst = 1'b0;
    #1;
    check("abort_mem_resp",  {31'b0, mem_resp},  32'h0);
    check("abort_imem_resp", {31'b0, imem_resp}, 32'h0);
    check("abort_instr",     instr,     32'h0);
    check("abort_mem_rdata", mem_rdata, 32'h0);
    tick();                       // edge that would have committed the write
    mem_write = 1'b0;
    rst = 1'b1;
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (mem_resp) pulses++;
    end
    check("abort_no_resp", pulses, 32'd0);
    dmem_op(1'b1, 1'b0, 32'h30, 32'h0, 4'h0, rdata, lat);
    check("abort_write_dropped", rdata, 32'h0BAD_F00D);

    // imem_read held for 10 cycles: pulses on alternate cycles.
    pc = 32'h40;
    imem_read = 1'b1;
    pulses = 0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      check($sformatf("stream_cycle%0d", c), {31'b0, imem_resp}, {31'b0, c[0]});
      if (imem_resp) begin
        pulses++;
        check($sformatf("stream_instr%0d", c), instr, 32'h7777_8888);
      end
    end
    imem_read = 1'b0;
    check("stream_pulse_count", pulses, 32'd5);
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_responder.md
# mem_responder

Dual-port memory responder that sits on the far side of the core's instruction-fetch and data-memory request interfaces. It serves instruction reads and data reads/writes out of one unified word array, with a fixed, parameterized response latency per port and a single-cycle response pulse. It is used as the memory target in core-level simulation and as the on-chip BRAM front end.

## Interface
- ADDR_WIDTH, 10: word-index bits; the array holds 2^ADDR_WIDTH 32-bit words.
- IMEM_LATENCY, 1: cycles from request acceptance to `imem_resp`. Must be ≥1.
- DMEM_LATENCY, 2: cycles from request acceptance to `mem_resp`. Must be ≥1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- pc  input  32  instruction fetch byte address.
- imem_read  input  1  instruction read request.
- instr  output  32  instruction read data; valid while `imem_resp` is high.
- imem_resp  output  1  one-cycle instruction response pulse.
- mem_address  input  32  data byte address.
- mem_read  input  1  data read request.
- mem_write  input  1  data write request.
- mem_byte_enable  input  4  per-byte write enable; bit i enables byte i, where byte 0 is bits [7:0].
- mem_wdata  input  32  write data.
- mem_rdata  output  32  data read data; valid while `mem_resp` is high.
- mem_resp  output  1  one-cycle data response pulse.

## Operation
- Each port has an independent FSM with states IDLE, BUSY and RESP, plus a down-counter.
- Port behaviour by state:
  - IDLE: a request that is high at the rising edge is accepted. The FSM latches the address (and, for dmem, wdata, byte enables and the read/write type) and loads counter = LATENCY−1. It goes to RESP if the loaded value is 0, otherwise to BUSY.
  - BUSY: the counter decrements each edge. The edge that sees counter==1 moves the FSM to RESP.
  - RESP: the response is high for exactly one cycle, then the FSM returns to IDLE. Requests present in RESP are ignored.
- The requester holds its request and data stable until it sees the response. Inputs sampled after acceptance are ignored.
- Addressing:
  - Word index = address[ADDR_WIDTH+1:2].
  - address[1:0] is ignored, so accesses are always word aligned.
  - Upper address bits are ignored, so addresses wrap.
- Data reads: read data is registered from the array on the edge that enters RESP. It is held until the next response and is not cleared after the pulse.
- Data writes:
  - Enabled bytes are committed on the edge that enters RESP.
  - `mem_rdata` is unchanged by a write.
  - If `mem_byte_enable` is 4'h0, nothing is written, but the response is still given.
- `mem_read` and `mem_write` both high on acceptance: the access is treated as a write.
- Instruction port: read-only.
- Same-edge conflict (imem read and dmem write to the same word on the same edge): the read returns the old data. Two dmem accesses can never coincide.
- Reset:
  - Asserting `rst` mid-operation aborts any pending access. No response is produced and an uncommitted write is dropped.
  - The array contents are not reset.

## Timing
- Reset values: `imem_resp`=0, `mem_resp`=0, `instr`=32'h0, `mem_rdata`=32'h0, both FSMs IDLE, counters 0.
- Latency: a request accepted at edge t produces a response high during the cycle after edge t+LATENCY−1. With LATENCY=1, the response is high in the cycle immediately after the accepting edge.
- Peak throughput per port: one access per LATENCY+1 cycles. A request held continuously is accepted again on the first edge in IDLE after RESP.
- The two ports never stall each other.

## Configuration
- MEM_RESPONDER_STALL_EN: when defined, a random stall is added to each accepted access.
  - An 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1), reset to 8'hA5 and stepped every cycle, supplies the stall.
  - On acceptance, LFSR[1:0] extra cycles (0–3) are added to that access's latency. Each port samples the shared LFSR on its own acceptance edge.
  - Purpose: stressing the requester's handshake handling.
- When not defined, latency is exactly the parameter value and no LFSR is built.

## Test plan
- Reset, then dmem write 32'hDEADBEEF to 0x10 with byte enables 4'hF → `mem_resp` pulses 2 cycles after acceptance. A subsequent read of 0x10 returns 32'hDEADBEEF.
- Partial write of 32'h0000AB00 to 0x10 with byte enables 4'b0010 over 32'hDEADBEEF → reading 0x10 returns 32'hDEADABEF. A write with byte enables 4'h0 → response given, word unchanged.
- dmem write of 32'h12345678 to 0x20 and an imem read of 0x20, with both responses landing on the same edge → `instr` returns the old word. The next imem read of 0x20 returns 32'h12345678.
- `rst` pulsed low while a write to 0x30 is in BUSY → no `mem_resp`, all outputs 0, and 0x30 keeps its prior value.
- Address wrap with ADDR_WIDTH=10: write 32'hCAFEF00D to 0x1012 → reading 0x0010 returns 32'hCAFEF00D.
- `imem_read` held high for 10 cycles with IMEM_LATENCY=1 → `imem_resp` pulses on alternate cycles (5 pulses), each pulse being a single cycle.
